// File: rtl/mcycle_muldiv.sv
// Multi-cycle integer multiply/divide: shift-add multiplier and restoring divider,
// one partial step per cycle, with sign handling and condition flags.
//
//  state     | meaning
//  IDLE      | waiting for Start
//  COMPUTING | one mul/div step per cycle, WIDTH steps
//  DONE      | results just registered, Done high for this cycle
module mcycle_muldiv #(
   parameter int WIDTH = 32
) (
   input  logic             CLK,
   input  logic             Reset,
   input  logic             Start,
   input  logic [1:0]       MCycleOp,
   input  logic [WIDTH-1:0] Operand1,
   input  logic [WIDTH-1:0] Operand2,
   output logic [WIDTH-1:0] Result1,
   output logic [WIDTH-1:0] Result2,
   output logic [3:0]       Flags,
   output logic             Busy,
   output logic             Done
);
   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      COMPUTING = 2'd1,
      DONE      = 2'd2
   } state_t;

   state_t             state_q;
   logic [CW-1:0]      cnt_q;
   logic               is_div_q, qneg_q, rneg_q, done_q;
   logic [WIDTH-1:0]   op1_q, b_q;
   logic [2*WIDTH-1:0] acc_q, acc_d;
   logic [WIDTH-1:0]   r1_q, r2_q, r1_d, r2_d;
   logic [3:0]         flags_q, flags_d;

   logic               sign1, sign2;
   logic [WIDTH-1:0]   mag1, mag2;
   logic [WIDTH:0]     sum, shifted, diff;
   logic [2*WIDTH-1:0] prod;
   logic [WIDTH-1:0]   quo, rem;

   assign sign1 = MCycleOp[0] & Operand1[WIDTH-1];
   assign sign2 = MCycleOp[0] & Operand2[WIDTH-1];
   assign mag1  = sign1 ? -Operand1 : Operand1;
   assign mag2  = sign2 ? -Operand2 : Operand2;

   // acc holds {high product, multiplier} for mul and {remainder, dividend/quotient} for div
   always_comb begin
      sum     = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, b_q} : {(WIDTH+1){1'b0}});
      shifted = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
      diff    = shifted - {1'b0, b_q};
      if (is_div_q) begin
         if (diff[WIDTH]) acc_d = {shifted[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
         else             acc_d = {diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
      end else begin
         acc_d = {sum, acc_q[WIDTH-1:1]};
      end
   end

   always_comb begin
      prod = qneg_q ? -acc_d : acc_d;
      quo  = qneg_q ? -acc_d[WIDTH-1:0] : acc_d[WIDTH-1:0];
      rem  = rneg_q ? -acc_d[2*WIDTH-1:WIDTH] : acc_d[2*WIDTH-1:WIDTH];
      r1_d = prod[WIDTH-1:0];
      r2_d = prod[2*WIDTH-1:WIDTH];
      if (is_div_q) begin
         if (b_q == '0) begin
            r1_d = '1;
            r2_d = op1_q;
         end else begin
            r1_d = quo;
            r2_d = rem;
         end
      end
      flags_d = {r1_d[WIDTH-1], (r1_d == '0), 2'b00};
   end

   always_ff @(posedge CLK) begin
      if (Reset) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         is_div_q <= 1'b0;
         qneg_q   <= 1'b0;
         rneg_q   <= 1'b0;
         op1_q    <= '0;
         b_q      <= '0;
         acc_q    <= '0;
         r1_q     <= '0;
         r2_q     <= '0;
         flags_q  <= '0;
         done_q   <= 1'b0;
      end else begin
         case (state_q)
            IDLE, DONE: begin
               done_q <= 1'b0;
               if (Start) begin
                  op1_q    <= Operand1;
                  b_q      <= mag2;
                  acc_q    <= {{WIDTH{1'b0}}, mag1};
                  is_div_q <= MCycleOp[1];
                  qneg_q   <= sign1 ^ sign2;
                  rneg_q   <= sign1;
                  cnt_q    <= '0;
                  state_q  <= COMPUTING;
               end else begin
                  state_q  <= IDLE;
               end
            end
            COMPUTING: begin
               acc_q <= acc_d;
               cnt_q <= cnt_q + CW'(1);
               if (cnt_q == LAST) begin
                  r1_q    <= r1_d;
                  r2_q    <= r2_d;
                  flags_q <= flags_d;
                  done_q  <= 1'b1;
                  state_q <= DONE;
               end
            end
            default: begin
               done_q  <= 1'b0;
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign Busy    = (state_q == COMPUTING) | Start;
   assign Done    = done_q;
   assign Result1 = r1_q;
   assign Result2 = r2_q;
   assign Flags   = flags_q;
endmodule

// File: doc/mcycle_muldiv.md
Name: mcycle_muldiv

Overview:
- Multi-cycle integer multiply/divide unit sitting in the execute stage beside the ALU, directly upstream of the condition/flag logic.
- Its Flags output is muxed into the ALUFlags input of the condition logic for MUL/DIV instructions that set flags.
- Busy stalls the processor while an operation is in flight.
- Uses a shift-add multiplier and a restoring divider, one partial step per cycle.

Parameters:
WIDTH, 32, operand and result width in bits (≥4).

Ports:
CLK  input  1  system clock, rising edge.
Reset  input  1  synchronous, active-high reset.
Start  input  1  request a new operation; sampled when not computing.
MCycleOp  input  2  00 unsigned mul, 01 signed mul, 10 unsigned div, 11 signed div.
Operand1  input  WIDTH  multiplicand / dividend.
Operand2  input  WIDTH  multiplier / divisor.
Result1  output  WIDTH  product low half / quotient.
Result2  output  WIDTH  product high half / remainder.
Flags  output  4  {N,Z,C,V} for the condition logic.
Busy  output  1  stall request.
Done  output  1  one-cycle pulse: results valid.

Behaviour:
- States: IDLE, COMPUTING, DONE. Reset (synchronous, CLK edge with Reset=1, any state including mid-operation) does all of the following:
  - state goes to IDLE;
  - Result1, Result2 and Flags are cleared to 0;
  - Done=0, Busy=0;
  - any in-flight operation is discarded.
- IDLE or DONE with Start=1:
  - Operand1, Operand2 and MCycleOp are latched.
  - Operands are converted to magnitudes for signed ops; the result sign is recorded.
  - The counter is cleared and state goes to COMPUTING.
- IDLE or DONE with Start=0: DONE returns to IDLE; IDLE stays in IDLE.
- Busy is combinational: 1 in COMPUTING, and 1 in IDLE/DONE when Start=1. Otherwise 0.
- COMPUTING:
  - Exactly one shift-add or restore-subtract step is performed per cycle, for WIDTH cycles (counter 0..WIDTH-1, width $clog2(WIDTH)).
  - On the edge ending step WIDTH-1, the sign-corrected results are registered into Result1/Result2/Flags and state goes to DONE.
  - Start is ignored in this state.
- Latency: Start accepted at edge k; Done=1 during the cycle after edge k+WIDTH; Busy falls in that same cycle.
- DONE:
  - Done=1 for exactly one cycle.
  - Results hold until the next operation completes or reset. Intermediate values are never visible on Result1/Result2.
- Multiply: 2·WIDTH-bit product, with Result2 holding the high half and Result1 the low half.
  - Signed: magnitude product, negated in two's complement over 2·WIDTH bits if the operand signs differ.
- Divide, unsigned: quotient to Result1, remainder to Result2.
- Divide, signed:
  - Quotient sign = sign1 XOR sign2, truncating toward zero.
  - Remainder takes the dividend's sign.
  - Most-negative / −1: quotient = most-negative value (wraps), remainder = 0.
- Divide by zero (either signedness): Result1 = all ones, Result2 = Operand1 unchanged. Flags are computed normally.
- Flags:
  - N = Result1[WIDTH-1].
  - Z = (Result1 == 0), low word only for multiply.
  - C = 0, V = 0 always.
- Back-to-back: Start held high in DONE launches the next operation immediately. Done=1 and Busy=1 in that cycle, and the new operands are latched.

Test Plan:
- Reset, then MCycleOp=00, Operand1=7, Operand2=6, Start for 1 cycle → Busy=1 for 33 cycles, Done pulses once, Result1=42, Result2=0, Flags=0000.
- MCycleOp=01, −3 × 5 → Result1=0xFFFFFFF1, Result2=0xFFFFFFFF, Flags=1000; and 0x80000000 × 2 unsigned → Result1=0, Result2=1, Flags=0100.
- MCycleOp=10, 100 / 7 → Result1=14, Result2=2. MCycleOp=11, −7 / 2 → Result1=0xFFFFFFFD, Result2=0xFFFFFFFF. 0x80000000 / 0xFFFFFFFF signed → Result1=0x80000000, Result2=0, N=1.
- Divide by zero, 5 / 0 unsigned and signed → Result1=0xFFFFFFFF, Result2=5, N=1, Z=0; the unit returns to IDLE normally.
- Reset asserted at cycle 10 of a multiply → next cycle IDLE, Busy=0, Done=0, Result1=Result2=0. No Done pulse follows. Start toggled mid-COMPUTING has no effect on results.
- Start held high across two operations (6×7, then 9/4) → Done pulses twice, 33 cycles apart. Result1/Result2 show 42/0 until the second Done, then 2/1.
